// File: rtl/dcpu_operand_unit.sv
// rtl/dcpu_operand_unit.sv - DCPU-16 operand fetch/address unit with req/ack RAM read port
module dcpu_operand_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int NW_TICKS = 0
) (
    input  logic                CORE_CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic [15:0]         INSTR,
    input  logic [8*DATA_W-1:0] REGS,
    input  logic [DATA_W-1:0]   PC_IN,
    input  logic [DATA_W-1:0]   SP_IN,
    input  logic [DATA_W-1:0]   EX_IN,
    output logic                MEM_REQ,
    output logic [ADDR_W-1:0]   MEM_ADDR,
    input  logic                MEM_ACK,
    input  logic [DATA_W-1:0]   MEM_RDATA,
    output logic                BUSY,
    output logic                DONE,
    output logic [DATA_W-1:0]   A_VAL,
    output logic [DATA_W-1:0]   B_VAL,
    output logic [1:0]          B_KIND,
    output logic [4:0]          B_SEL,
    output logic [ADDR_W-1:0]   B_ADDR,
    output logic [DATA_W-1:0]   PC_OUT,
    output logic [DATA_W-1:0]   SP_OUT,
    output logic [1:0]          NW_COUNT
);

    localparam logic [1:0] K_REG  = 2'd0;
    localparam logic [1:0] K_MEM  = 2'd1;
    localparam logic [1:0] K_SPC  = 2'd2;
    localparam logic [1:0] K_NONE = 2'd3;

    typedef enum logic [3:0] {
        IDLE, A_DEC, A_NW, A_MEM, B_DEC, B_NW, B_MEM, STALL, FINISH
    } state_t;

    state_t              state;
    logic [15:0]         instr_q;
    logic [8*DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]   pc_in_q, ex_q, pc_q, sp_q, base_q;
    logic [DATA_W-1:0]   a_val_q, b_val_q;
    logic [1:0]          b_kind_q, nw_cnt_q;
    logic [ADDR_W-1:0]   b_addr_q, mem_addr_q;
    logic                nw_lit_q, skip_q;
    logic [31:0]         stall_q;

    logic [5:0]          fld;
    logic [DATA_W-1:0]   reg_val, sp_dec, nw_sum;
    logic                d_nw, d_mem, d_lit, skip_b, special;
    logic [1:0]          d_kind;
    logic [DATA_W-1:0]   d_val, d_base, d_sp;
    logic [ADDR_W-1:0]   d_addr;
    logic [31:0]         stall_cur, stall_nxt;

    assign reg_val   = regs_q[32'(fld[2:0]) * DATA_W +: DATA_W];
    assign sp_dec    = sp_q - DATA_W'(1);
    assign nw_sum    = base_q + MEM_RDATA;
    assign special   = (instr_q[4:0] == 5'h00);
    assign skip_b    = (instr_q[4:0] == 5'h01) || (fld == 6'h18);
    assign stall_cur = 32'(NW_TICKS) * 32'(nw_cnt_q);
    assign stall_nxt = 32'(NW_TICKS) * 32'(nw_cnt_q + 2'd1);

    // Operand decode shared by both fields; b differs only in PUSH for 0x18 and literal kind.
    always_comb begin
        fld    = (state == A_DEC) ? instr_q[15:10] : {1'b0, instr_q[9:5]};
        d_nw   = 1'b0;
        d_mem  = 1'b0;
        d_lit  = 1'b0;
        d_kind = K_REG;
        d_val  = '0;
        d_base = '0;
        d_addr = '0;
        d_sp   = sp_q;
        if (fld < 6'h08) begin
            d_val = reg_val;
        end else if (fld < 6'h10) begin
            d_mem  = 1'b1;
            d_kind = K_MEM;
            d_addr = reg_val[ADDR_W-1:0];
        end else if (fld < 6'h18) begin
            d_nw   = 1'b1;
            d_mem  = 1'b1;
            d_kind = K_MEM;
            d_base = reg_val;
        end else begin
            case (fld)
                6'h18: begin
                    d_mem  = 1'b1;
                    d_kind = K_MEM;
                    if (state == A_DEC) begin
                        d_addr = sp_q[ADDR_W-1:0];
                        d_sp   = sp_q + DATA_W'(1);
                    end else begin
                        d_addr = sp_dec[ADDR_W-1:0];
                        d_sp   = sp_dec;
                    end
                end
                6'h19: begin
                    d_mem  = 1'b1;
                    d_kind = K_MEM;
                    d_addr = sp_q[ADDR_W-1:0];
                end
                6'h1A: begin
                    d_nw   = 1'b1;
                    d_mem  = 1'b1;
                    d_kind = K_MEM;
                    d_base = sp_q;
                end
                6'h1B: begin d_kind = K_SPC; d_val = sp_q;    end
                6'h1C: begin d_kind = K_SPC; d_val = pc_in_q; end
                6'h1D: begin d_kind = K_SPC; d_val = ex_q;    end
                6'h1E: begin
                    d_nw   = 1'b1;
                    d_mem  = 1'b1;
                    d_kind = K_MEM;
                end
                6'h1F: begin
                    d_nw   = 1'b1;
                    d_lit  = 1'b1;
                    d_kind = K_NONE;
                end
                default: begin
                    d_kind = K_NONE;
                    d_val  = {{(DATA_W-6){1'b0}}, fld} - DATA_W'(33);
                end
            endcase
        end
    end

    always_ff @(posedge CORE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            instr_q    <= '0;
            regs_q     <= '0;
            pc_in_q    <= '0;
            ex_q       <= '0;
            pc_q       <= '0;
            sp_q       <= '0;
            base_q     <= '0;
            a_val_q    <= '0;
            b_val_q    <= '0;
            b_kind_q   <= '0;
            nw_cnt_q   <= '0;
            b_addr_q   <= '0;
            mem_addr_q <= '0;
            nw_lit_q   <= 1'b0;
            skip_q     <= 1'b0;
            stall_q    <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    instr_q  <= INSTR;
                    regs_q   <= REGS;
                    pc_in_q  <= PC_IN;
                    pc_q     <= PC_IN;
                    sp_q     <= SP_IN;
                    ex_q     <= EX_IN;
                    a_val_q  <= '0;
                    b_val_q  <= '0;
                    b_kind_q <= K_REG;
                    b_addr_q <= '0;
                    nw_cnt_q <= '0;
                    state    <= A_DEC;
                end
                A_DEC: begin
                    sp_q     <= d_sp;
                    base_q   <= d_base;
                    nw_lit_q <= d_lit;
                    if (d_nw) begin
                        mem_addr_q <= pc_q[ADDR_W-1:0];
                        state      <= A_NW;
                    end else if (d_mem) begin
                        mem_addr_q <= d_addr;
                        state      <= A_MEM;
                    end else begin
                        a_val_q <= d_val;
                        state   <= B_DEC;
                    end
                end
                A_NW: if (MEM_ACK) begin
                    pc_q     <= pc_q + DATA_W'(1);
                    nw_cnt_q <= nw_cnt_q + 2'd1;
                    if (nw_lit_q) begin
                        a_val_q <= MEM_RDATA;
                        state   <= B_DEC;
                    end else begin
                        mem_addr_q <= nw_sum[ADDR_W-1:0];
                        state      <= A_MEM;
                    end
                end
                A_MEM: if (MEM_ACK) begin
                    a_val_q <= MEM_RDATA;
                    state   <= B_DEC;
                end
                B_DEC: begin
                    if (special) begin
                        b_kind_q <= K_NONE;
                        stall_q  <= stall_cur;
                        state    <= (stall_cur != 32'd0) ? STALL : FINISH;
                    end else begin
                        sp_q     <= d_sp;
                        base_q   <= d_base;
                        nw_lit_q <= d_lit;
                        skip_q   <= skip_b;
                        b_kind_q <= d_kind;
                        if (d_nw) begin
                            mem_addr_q <= pc_q[ADDR_W-1:0];
                            state      <= B_NW;
                        end else if (d_mem && !skip_b) begin
                            b_addr_q   <= d_addr;
                            mem_addr_q <= d_addr;
                            state      <= B_MEM;
                        end else begin
                            b_addr_q <= d_addr;
                            b_val_q  <= d_mem ? '0 : d_val;
                            stall_q  <= stall_cur;
                            state    <= (stall_cur != 32'd0) ? STALL : FINISH;
                        end
                    end
                end
                B_NW: if (MEM_ACK) begin
                    pc_q     <= pc_q + DATA_W'(1);
                    nw_cnt_q <= nw_cnt_q + 2'd1;
                    if (nw_lit_q || skip_q) begin
                        if (nw_lit_q) b_val_q  <= MEM_RDATA;
                        else          b_addr_q <= nw_sum[ADDR_W-1:0];
                        stall_q <= stall_nxt;
                        state   <= (stall_nxt != 32'd0) ? STALL : FINISH;
                    end else begin
                        b_addr_q   <= nw_sum[ADDR_W-1:0];
                        mem_addr_q <= nw_sum[ADDR_W-1:0];
                        state      <= B_MEM;
                    end
                end
                B_MEM: if (MEM_ACK) begin
                    b_val_q <= MEM_RDATA;
                    stall_q <= stall_cur;
                    state   <= (stall_cur != 32'd0) ? STALL : FINISH;
                end
                STALL: begin
                    if (stall_q <= 32'd1) state <= FINISH;
                    else                  stall_q <= stall_q - 32'd1;
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request decodes straight from the state register so reset drops it without waiting for a clock.
    assign MEM_REQ  = (state == A_NW) || (state == A_MEM) || (state == B_NW) || (state == B_MEM);
    assign MEM_ADDR = mem_addr_q;
    assign BUSY     = (state != IDLE);
    assign DONE     = (state == FINISH);
    assign A_VAL    = a_val_q;
    assign B_VAL    = b_val_q;
    assign B_KIND   = b_kind_q;
    assign B_SEL    = instr_q[9:5];
    assign B_ADDR   = b_addr_q;
    assign PC_OUT   = pc_q;
    assign SP_OUT   = sp_q;
    assign NW_COUNT = nw_cnt_q;

endmodule

// File: tb/tb_dcpu_operand_unit.sv
// tb/tb_dcpu_operand_unit.sv - directed self-checking bench for dcpu_operand_unit
module tb_dcpu_operand_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 16-bit instance, zero stall padding
    logic        start16 = 1'b0;
    logic [15:0] instr16 = '0;
    logic [127:0] regs16 = '0;
    logic [15:0] pc16 = '0, sp16 = '0, ex16 = '0;
    logic        req16, ack16 = 1'b0, busy16, done16;
    logic [15:0] addr16, rdata16 = '0;
    logic [15:0] aval16, bval16, baddr16, pco16, spo16;
    logic [1:0]  bkind16, nwc16;
    logic [4:0]  bsel16;

    dcpu_operand_unit dut16 (
        .CORE_CLK(clk), .RESET_N(rst_n), .START(start16), .INSTR(instr16), .REGS(regs16),
        .PC_IN(pc16), .SP_IN(sp16), .EX_IN(ex16), .MEM_REQ(req16), .MEM_ADDR(addr16),
        .MEM_ACK(ack16), .MEM_RDATA(rdata16), .BUSY(busy16), .DONE(done16), .A_VAL(aval16),
        .B_VAL(bval16), .B_KIND(bkind16), .B_SEL(bsel16), .B_ADDR(baddr16), .PC_OUT(pco16),
        .SP_OUT(spo16), .NW_COUNT(nwc16)
    );

    // 32-bit instance with two stall ticks per next-word
    logic        start32 = 1'b0;
    logic [15:0] instr32 = '0;
    logic [255:0] regs32 = '0;
    logic [31:0] pc32 = '0, sp32 = '0, ex32 = '0;
    logic        req32, model_ack32 = 1'b0, force_ack32 = 1'b0, ack32, busy32, done32;
    logic [15:0] addr32, baddr32;
    logic [31:0] rdata32 = '0, aval32, bval32, pco32, spo32;
    logic [1:0]  bkind32, nwc32;
    logic [4:0]  bsel32;
    assign ack32 = model_ack32 | force_ack32;

    dcpu_operand_unit #(.DATA_W(32), .ADDR_W(16), .NW_TICKS(2)) dut32 (
        .CORE_CLK(clk), .RESET_N(rst_n), .START(start32), .INSTR(instr32), .REGS(regs32),
        .PC_IN(pc32), .SP_IN(sp32), .EX_IN(ex32), .MEM_REQ(req32), .MEM_ADDR(addr32),
        .MEM_ACK(ack32), .MEM_RDATA(rdata32), .BUSY(busy32), .DONE(done32), .A_VAL(aval32),
        .B_VAL(bval32), .B_KIND(bkind32), .B_SEL(bsel32), .B_ADDR(baddr32), .PC_OUT(pco32),
        .SP_OUT(spo32), .NW_COUNT(nwc32)
    );

    // RAM models: ack after delay wait cycles, address must hold while waiting
    logic [15:0] mem16 [logic [15:0]];
    logic [31:0] mem32 [logic [15:0]];
    logic [15:0] log16[$];
    int delay16 = 0, wcnt16 = 0, delay32 = 0, wcnt32 = 0;
    logic [15:0] hold16 = '0, hold32 = '0;

    always @(negedge clk) begin
        if (req16) begin
            if (wcnt16 == 0) hold16 = addr16;
            else check("addr16_stable", addr16, hold16);
            if (wcnt16 >= delay16) begin
                ack16 = 1'b1;
                rdata16 = mem16.exists(addr16) ? mem16[addr16] : 16'h0;
                log16.push_back(addr16);
                wcnt16 = 0;
            end else begin
                ack16 = 1'b0;
                wcnt16++;
            end
        end else begin
            ack16 = 1'b0;
            wcnt16 = 0;
        end
    end

    always @(negedge clk) begin
        if (req32) begin
            if (wcnt32 == 0) hold32 = addr32;
            else check("addr32_stable", addr32, hold32);
            if (wcnt32 >= delay32) begin
                model_ack32 = 1'b1;
                rdata32 = mem32.exists(addr32) ? mem32[addr32] : 32'h0;
                wcnt32 = 0;
            end else begin
                model_ack32 = 1'b0;
                wcnt32++;
            end
        end else begin
            model_ack32 = 1'b0;
            wcnt32 = 0;
        end
    end

    // edges = index of the clock edge that samples DONE high, START's edge being 1
    task automatic run16(input logic [15:0] ins, output int edges);
        int n;
        log16.delete();
        instr16 = ins;
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        n = 1;
        while (!done16 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("run16_timeout", 64'(n), 64'd0);
        edges = n + 1;
        @(posedge clk); #1;
        check("done16_pulse", 64'(done16), 64'd0);
    endtask

    task automatic run32(input logic [15:0] ins, output int edges);
        int n;
        instr32 = ins;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("run32_timeout", 64'(n), 64'd0);
        edges = n + 1;
        @(posedge clk); #1;
    endtask

    int e;
    int saw_done;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy16), 64'd0);
        check("rst_done",  64'(done16), 64'd0);
        check("rst_req",   64'(req16),  64'd0);
        check("rst_aval",  64'(aval16), 64'd0);
        check("rst_pcout", 64'(pco16),  64'd0);
        check("rst_bkind", 64'(bkind16), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SET A,0x0F: literal a, register b, no reads
        regs16 = '0;
        regs16[15:0] = 16'h5555;
        pc16 = 16'h0300; sp16 = 16'h1000;
        run16(16'hC001, e);
        check("lit_edges", 64'(e), 64'd4);
        check("lit_aval",  64'(aval16), 64'h000F);
        check("lit_bkind", 64'(bkind16), 64'd0);
        check("lit_bsel",  64'(bsel16), 64'd0);
        check("lit_pcout", 64'(pco16), 64'h0300);
        check("lit_reads", 64'(log16.size()), 64'd0);

        // ADD [B+nw],POP with zero-wait memory
        regs16 = '0;
        regs16[31:16] = 16'h0100;
        pc16 = 16'h0200; sp16 = 16'hFFFF;
        mem16[16'hFFFF] = 16'h0005;
        mem16[16'h0200] = 16'h0010;
        mem16[16'h0110] = 16'h0007;
        delay16 = 0;
        run16(16'h6222, e);
        check("stk_edges", 64'(e), 64'd7);
        check("stk_nreads", 64'(log16.size()), 64'd3);
        if (log16.size() == 3) begin
            check("stk_addr0", 64'(log16[0]), 64'hFFFF);
            check("stk_addr1", 64'(log16[1]), 64'h0200);
            check("stk_addr2", 64'(log16[2]), 64'h0110);
        end
        check("stk_aval",  64'(aval16), 64'd5);
        check("stk_bval",  64'(bval16), 64'd7);
        check("stk_bkind", 64'(bkind16), 64'd1);
        check("stk_baddr", 64'(baddr16), 64'h0110);
        check("stk_pcout", 64'(pco16), 64'h0201);
        check("stk_spout", 64'(spo16), 64'h0000);
        check("stk_nwc",   64'(nwc16), 64'd1);

        // Same instruction, three wait cycles on every read
        delay16 = 3;
        run16(16'h6222, e);
        check("bp_edges", 64'(e), 64'd16);
        check("bp_aval",  64'(aval16), 64'd5);
        check("bp_bval",  64'(bval16), 64'd7);
        check("bp_baddr", 64'(baddr16), 64'h0110);
        check("bp_spout", 64'(spo16), 64'h0000);
        delay16 = 0;

        // JSR nw: special op, b untouched
        pc16 = 16'h0010; sp16 = 16'h0800;
        mem16[16'h0010] = 16'h1234;
        run16(16'h7C20, e);
        check("jsr_edges", 64'(e), 64'd5);
        check("jsr_aval",  64'(aval16), 64'h1234);
        check("jsr_bkind", 64'(bkind16), 64'd3);
        check("jsr_pcout", 64'(pco16), 64'h0011);
        check("jsr_spout", 64'(spo16), 64'h0800);
        check("jsr_nreads", 64'(log16.size()), 64'd1);

        // SET PUSH,A: address resolved, no b read
        regs16[15:0] = 16'h00AA;
        sp16 = 16'h0000;
        run16(16'h0301, e);
        check("push_edges", 64'(e), 64'd4);
        check("push_baddr", 64'(baddr16), 64'hFFFF);
        check("push_spout", 64'(spo16), 64'hFFFF);
        check("push_bkind", 64'(bkind16), 64'd1);
        check("push_bval",  64'(bval16), 64'd0);
        check("push_aval",  64'(aval16), 64'h00AA);
        check("push_nreads", 64'(log16.size()), 64'd0);

        // 32-bit: literal -1 wraps to all ones, no stall without next-words
        pc32 = 32'h0000_0040; sp32 = 32'h0000_0100;
        run32(16'h8001, e);
        check("w32_lit_edges", 64'(e), 64'd4);
        check("w32_lit_aval",  64'(aval32), 64'hFFFF_FFFF);

        // 32-bit: one next-word gives two stall cycles
        mem32[16'h0040] = 32'hDEAD_BEEF;
        delay32 = 0;
        run32(16'h7C01, e);
        check("w32_nw_edges", 64'(e), 64'd7);
        check("w32_nw_aval",  64'(aval32), 64'hDEAD_BEEF);
        check("w32_nw_pcout", 64'(pco32), 64'h41);
        check("w32_nw_nwc",   64'(nwc32), 64'd1);

        // Reset while the a next-word read is waiting on ACK
        delay32 = 20;
        instr32 = 16'h7C01;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_req_before", 64'(req32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req", 64'(req32), 64'd0);
        check("abort_busy", 64'(busy32), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_ack32 = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done32 || busy32) saw_done++;
        end
        force_ack32 = 1'b0;
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_aval",  64'(aval32), 64'd0);
        check("abort_pcout", 64'(pco32), 64'd0);
        delay32 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
